// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder.
// Captures a word load/store request and waits a fixed number of cycles.
// It then accesses an internal word RAM and pulses ready for one cycle.
// Misaligned requests skip the RAM access and complete with err set.
module data_mem_responder #(
    parameter int unsigned AW_WORDS    = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned Depth = 1 << AW_WORDS;
    localparam int unsigned AddrKeep = AW_WORDS + 2;
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic                  write_q, write_d;
    logic [AddrKeep-1:0]   addr_q, addr_d;
    logic [31:0]           datain_q, datain_d;
    logic [31:0]           dataout_q, dataout_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  busy_q;

    logic [31:0]           mem [Depth];
    logic [AW_WORDS-1:0]   idx;
    logic                  aligned;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    // Upper address bits only select aliases of the same word, so they are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AddrKeep];

    assign idx       = addr_q[AddrKeep-1:2];
    assign aligned   = (addr_q[1:0] == 2'b00);
    assign mem_rdata = mem[idx];

    // Next-state, capture and completion logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        write_d   = write_q;
        addr_d    = addr_q;
        datain_d  = datain_q;
        dataout_d = dataout_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d  = StWait;
                    count_d  = WaitInit;
                    write_d  = write;
                    addr_d   = addr[AddrKeep-1:0];
                    datain_d = datain;
                end
            end
            StWait: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    state_d = StResp;
                    ready_d = 1'b1;
                    if (aligned) begin
                        if (write_q) begin
                            mem_we = 1'b1;
                        end else begin
                            dataout_d = mem_rdata;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StResp: begin
                // ready/err fall back to their defaults here; req is not sampled.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any captured request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            count_q   <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            datain_q  <= 32'd0;
            dataout_q <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            datain_q  <= datain_d;
            dataout_q <= dataout_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    // Word RAM write port; contents survive reset, and reset forces IDLE so no write is pending.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[idx] <= datain_q;
        end
    end

    assign dataout = dataout_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule
